// File: rtl/spi_mem_pkg.sv
// Shared constants and types for the SPI memory responder.
// SPI_MEM_RDSR_EN adds the RDSR/WRSR status-register opcodes.
package spi_mem_pkg;

   localparam logic [7:0] OP_READ    = 8'h03;
   localparam logic [7:0] OP_WRITE   = 8'h02;
   localparam logic [7:0] OP_RDSR    = 8'h05;
   localparam logic [7:0] OP_WRSR    = 8'h01;
   localparam logic [7:0] STATUS_RST = 8'h40;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StRead,
      StWrite,
      StIgnore
   } state_e;

   function automatic logic is_mem_op(input logic [7:0] op);
      return (op == OP_READ) || (op == OP_WRITE);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI input, plus rise/fall
// strobes derived from the synchronized value.
module spi_sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, sync_q, prev_q;

   // Reset to 0: a chip select held low across reset produces no false fall.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign q_o    = sync_q;
   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory target: READ (0x03) / WRITE (0x02) with 24-bit address.
// Define SPI_MEM_RDSR_EN to add RDSR (0x05) and WRSR (0x01).
module spi_mem_responder
   import spi_mem_pkg::*;
#(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic miso,
   output logic miso_oe,
   output logic wr_done,
   output logic cmd_err
);

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic mosi_s, mosi_rise, mosi_fall;
   logic unused_sync;

   spi_sync_edge u_sync_sclk (
      .clk_i  (clk),
      .rst_i  (rst),
      .d_i    (sclk),
      .q_o    (sclk_s),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   spi_sync_edge u_sync_cs (
      .clk_i  (clk),
      .rst_i  (rst),
      .d_i    (cs_n),
      .q_o    (cs_s),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   spi_sync_edge u_sync_mosi (
      .clk_i  (clk),
      .rst_i  (rst),
      .d_i    (mosi),
      .q_o    (mosi_s),
      .rise_o (mosi_rise),
      .fall_o (mosi_fall)
   );

   assign unused_sync = ^{sclk_s, cs_s, mosi_rise, mosi_fall};

   state_e            state_q, state_d;
   logic [4:0]        bit_cnt_q;
   logic [7:0]        shift_q;
   logic [7:0]        tx_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_q;
   logic              miso_q;
   logic              wr_done_q;
   logic              cmd_err_q;
   logic [7:0]        mem_q [DEPTH];

   logic [7:0]        rx_byte;
   logic [ADDR_W-1:0] addr_shift;
   logic [ADDR_W-1:0] addr_inc;
   logic              wr_commit;
   logic              sr_sel;
   logic [7:0]        status_val;

   assign rx_byte    = {shift_q[6:0], mosi_s};
   assign addr_shift = {addr_q[ADDR_W-2:0], mosi_s};
   assign addr_inc   = addr_q + ADDR_W'(1);
   // A byte is only committed if cs_n is not rising in the same cycle.
   assign wr_commit  = (state_q == StWrite) && (state_d == StWrite) && sclk_rise &&
                       (bit_cnt_q == 5'd7);

`ifdef SPI_MEM_RDSR_EN
   logic       sr_q;
   logic [7:0] status_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q     <= 1'b0;
         status_q <= STATUS_RST;
      end else begin
         if (state_q == StCmd && state_d != StCmd) begin
            sr_q <= (rx_byte == OP_RDSR) || (rx_byte == OP_WRSR);
         end
         if (wr_commit && sr_q) begin
            status_q <= rx_byte;
         end
      end
   end

   assign sr_sel     = sr_q;
   assign status_val = status_q;
`else
   assign sr_sel     = 1'b0;
   assign status_val = STATUS_RST;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; cs_n rise overrides everything
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (cs_fall) state_d = StCmd;
         end
         StCmd: begin
            if (sclk_rise && bit_cnt_q == 5'd7) begin
               if (is_mem_op(rx_byte)) begin
                  state_d = StAddr;
`ifdef SPI_MEM_RDSR_EN
               end else if (rx_byte == OP_RDSR) begin
                  state_d = StRead;
               end else if (rx_byte == OP_WRSR) begin
                  state_d = StWrite;
`endif
               end else begin
                  state_d = StIgnore;
               end
            end
         end
         StAddr: begin
            if (sclk_rise && bit_cnt_q == 5'd23) state_d = rd_q ? StRead : StWrite;
         end
         default: ;
      endcase
      if (cs_rise) state_d = StIdle;
   end

   // Shift, count and address datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= '0;
         addr_q    <= '0;
         rd_q      <= 1'b0;
         miso_q    <= 1'b0;
         wr_done_q <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         wr_done_q <= 1'b0;
         cmd_err_q <= 1'b0;
         if (state_d != state_q) begin
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            if (state_q == StCmd) begin
               rd_q <= (rx_byte == OP_READ);
               if (state_d == StIgnore) cmd_err_q <= 1'b1;
            end
            if (state_q == StAddr) addr_q <= addr_shift;
            if (state_d == StRead) begin
               tx_q <= (state_q == StCmd) ? status_val : mem_q[addr_shift];
            end
         end else begin
            case (state_q)
               StCmd, StAddr: begin
                  if (sclk_rise) begin
                     shift_q   <= rx_byte;
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                     if (state_q == StAddr) addr_q <= addr_shift;
                  end
               end
               StRead: begin
                  if (sclk_fall) begin
                     miso_q <= tx_q[7];
                     if (bit_cnt_q == 5'd7) begin
                        bit_cnt_q <= '0;
                        if (sr_sel) begin
                           tx_q <= status_val;
                        end else begin
                           tx_q   <= mem_q[addr_inc];
                           addr_q <= addr_inc;
                        end
                     end else begin
                        tx_q      <= {tx_q[6:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                  end
               end
               StWrite: begin
                  if (sclk_rise) begin
                     shift_q <= rx_byte;
                     if (bit_cnt_q == 5'd7) begin
                        bit_cnt_q <= '0;
                        if (!sr_sel) begin
                           wr_done_q <= 1'b1;
                           addr_q    <= addr_inc;
                        end
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Storage array, cleared on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_commit && !sr_sel) begin
         mem_q[addr_q] <= rx_byte;
      end
   end

   // Outputs
   always_comb begin
      miso_oe = (state_q == StRead);
      miso    = miso_oe & miso_q;
      wr_done = wr_done_q;
      cmd_err = cmd_err_q;
   end

endmodule
